score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 233 +++++++++++++++++++++++
 tb/tb_score_keeper.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper -- rhythm-game scoring engine clocked once per video frame.
//
// Game flow: IDLE waits for the start key (8'h2C); PLAY runs for GAME_LEN
// frames while crediting dropper hits and arrow-key misses; DONE freezes all
// results until the acknowledge key (8'h01) returns to IDLE.
//
// Ports:
//   frame_clk       in   1       frame-rate clock, rising edge
//   Reset           in   1       synchronous, active-high reset
//   keycode         in   8       primary keyboard code
//   keycode_second  in   8       secondary keyboard code
//   score_in        in   N_DROP  per-dropper hit levels (high from hit until re-arm)
//   total_score     out  14      accumulated points, saturates at 9999
//   combo           out  8       current hit streak, saturates at 255
//   max_combo       out  8       longest streak this game
//   hit_count       out  10      hits this game, saturates at 1023
//   miss_count      out  10      misses this game, saturates at 1023
//   game_state      out  2       00 IDLE, 01 PLAY, 10 DONE
//   game_over       out  1       high while in DONE
module score_keeper #(
  parameter int N_DROP   = 32,
  parameter int GAME_LEN = 2400,
  parameter int PTS_HIT  = 10
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [7:0]        keycode,
  input  logic [7:0]        keycode_second,
  input  logic [N_DROP-1:0] score_in,
  output logic [13:0]       total_score,
  output logic [7:0]        combo,
  output logic [7:0]        max_combo,
  output logic [9:0]        hit_count,
  output logic [9:0]        miss_count,
  output logic [1:0]        game_state,
  output logic              game_over
);

  localparam int KW = $clog2(N_DROP + 1);
  localparam int TW = (GAME_LEN > 1) ? $clog2(GAME_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Number of set bits in a dropper vector (hits landing in one frame).
  function automatic logic [KW-1:0] popcount(input logic [N_DROP-1:0] v);
    logic [KW-1:0] c;
    c = '0;
    for (int i = 0; i < N_DROP; i++) begin
      c = c + KW'(v[i]);
    end
    return c;
  endfunction

  // True for the four cursor keys (right, left, down, up).
  function automatic logic is_arrow(input logic [7:0] code);
    logic r;
    case (code)
      8'h4F, 8'h50, 8'h51, 8'h52: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [13:0]       total_q, total_d;
  logic [7:0]        combo_q, combo_d;
  logic [7:0]        max_q, max_d;
  logic [9:0]        hit_q, hit_d;
  logic [9:0]        miss_q, miss_d;
  logic [N_DROP-1:0] prev_q, prev_d;
  logic              arrow_prev_q, arrow_prev_d;
  logic              press_d_q, press_d_d;

  logic [N_DROP-1:0] rise_s;
  logic [KW-1:0]     k_s;
  logic              arrow_now_s;
  logic              last_frame_s;
  logic [31:0]       pts_s;
  logic [31:0]       total_sum_s;
  logic [31:0]       combo_sum_s;
  logic [31:0]       hit_sum_s;
  logic [31:0]       miss_sum_s;
  logic [7:0]        combo_new_s;

  // Hit/press detection and saturating arithmetic shared by the FSM below.
  always_comb begin
    rise_s       = score_in & ~prev_q;
    k_s          = popcount(rise_s);
    arrow_now_s  = is_arrow(keycode) | is_arrow(keycode_second);
    last_frame_s = (timer_q == TW'(GAME_LEN - 1));

    // Streak bonus is decided by the combo held before this frame's hits.
    if (combo_q < 8'd10) begin
      pts_s = 32'(k_s) * 32'(PTS_HIT);
    end else begin
      pts_s = 32'(k_s) * 32'(PTS_HIT) * 32'd2;
    end

    total_sum_s = 32'(total_q) + pts_s;
    combo_sum_s = 32'(combo_q) + 32'(k_s);
    hit_sum_s   = 32'(hit_q) + 32'(k_s);
    miss_sum_s  = 32'(miss_q) + 32'd1;

    if (combo_sum_s > 32'd255) begin
      combo_new_s = 8'd255;
    end else begin
      combo_new_s = combo_sum_s[7:0];
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    total_d      = total_q;
    combo_d      = combo_q;
    max_d        = max_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    // Edge-detect history tracks every frame so levels already high at
    // game start never look like fresh hits.
    prev_d       = score_in;
    arrow_prev_d = arrow_now_s;
    press_d_d    = arrow_now_s & ~arrow_prev_q;

    case (state_q)
      S_IDLE: begin
        if (keycode == 8'h2C) begin
          state_d = S_PLAY;
          timer_d = '0;
          total_d = 14'd0;
          combo_d = 8'd0;
          max_d   = 8'd0;
          hit_d   = 10'd0;
          miss_d  = 10'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PLAY: begin
        if (k_s != '0) begin
          // A press coinciding with a hit is just the hit.
          if (total_sum_s > 32'd9999) begin
            total_d = 14'd9999;
          end else begin
            total_d = total_sum_s[13:0];
          end
          combo_d = combo_new_s;
          if (combo_new_s > max_q) begin
            max_d = combo_new_s;
          end else begin
            max_d = max_q;
          end
          if (hit_sum_s > 32'd1023) begin
            hit_d = 10'd1023;
          end else begin
            hit_d = hit_sum_s[9:0];
          end
        end else if (press_d_q && !last_frame_s) begin
          // Unmatched press breaks the streak; ignored on the final frame.
          combo_d = 8'd0;
          if (miss_sum_s > 32'd1023) begin
            miss_d = 10'd1023;
          end else begin
            miss_d = miss_sum_s[9:0];
          end
        end else begin
          combo_d = combo_q;
        end

        if (last_frame_s) begin
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DONE: begin
        if (keycode == 8'h01) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers; Reset wins over any same-cycle update.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      total_q      <= 14'd0;
      combo_q      <= 8'd0;
      max_q        <= 8'd0;
      hit_q        <= 10'd0;
      miss_q       <= 10'd0;
      prev_q       <= '0;
      arrow_prev_q <= 1'b0;
      press_d_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      total_q      <= total_d;
      combo_q      <= combo_d;
      max_q        <= max_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      prev_q       <= prev_d;
      arrow_prev_q <= arrow_prev_d;
      press_d_q    <= press_d_d;
    end
  end

  assign total_score = total_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;
  assign game_state  = state_q;
  assign game_over   = (state_q == S_DONE);

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam int N   = 32;
  localparam int GL  = 64;
  localparam int GL8 = 8;
  localparam int PTS = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    kc, kc2;
  logic [N-1:0]  sin;

  logic [13:0] tot, tot8;
  logic [7:0]  cmb, cmb8, mx, mx8;
  logic [9:0]  hit, hit8, mis, mis8;
  logic [1:0]  st, st8;
  logic        go, go8;

  int n_tests = 0;
  int n_fail  = 0;

  score_keeper #(.N_DROP(N), .GAME_LEN(GL), .PTS_HIT(PTS)) dut (
    .frame_clk(clk), .Reset(rst), .keycode(kc), .keycode_second(kc2),
    .score_in(sin), .total_score(tot), .combo(cmb), .max_combo(mx),
    .hit_count(hit), .miss_count(mis), .game_state(st), .game_over(go));

  score_keeper #(.N_DROP(N), .GAME_LEN(GL8), .PTS_HIT(PTS)) dut8 (
    .frame_clk(clk), .Reset(rst), .keycode(kc), .keycode_second(kc2),
    .score_in(sin), .total_score(tot8), .combo(cmb8), .max_combo(mx8),
    .hit_count(hit8), .miss_count(mis8), .game_state(st8), .game_over(go8));

  always #5 clk = ~clk;

  // ---------------- reference model (game rules, plain integers) -----------
  int          m_state, m_timer, m_total, m_combo, m_max, m_hit, m_miss;
  logic [N-1:0] m_prev;
  bit          m_arrow_prev, m_pressd;

  function automatic bit arrow_key(input logic [7:0] c);
    return (c >= 8'h4F) && (c <= 8'h52);
  endfunction

  task automatic step_model();
    int  k;
    int  pts;
    bit  arrow;
    bit  last;
    if (rst) begin
      m_state = 0; m_timer = 0; m_total = 0; m_combo = 0; m_max = 0;
      m_hit = 0; m_miss = 0; m_prev = '0; m_arrow_prev = 0; m_pressd = 0;
      return;
    end
    k     = $countones(sin & ~m_prev);
    arrow = arrow_key(kc) || arrow_key(kc2);
    case (m_state)
      0: if (kc == 8'h2C) begin
           m_state = 1; m_timer = 0; m_total = 0; m_combo = 0;
           m_max = 0; m_hit = 0; m_miss = 0;
         end
      1: begin
           last = (m_timer == GL - 1);
           if (k > 0) begin
             pts = k * PTS * ((m_combo >= 10) ? 2 : 1);
             m_total = (m_total + pts > 9999) ? 9999 : m_total + pts;
             m_combo = (m_combo + k > 255) ? 255 : m_combo + k;
             if (m_combo > m_max) m_max = m_combo;
             m_hit = (m_hit + k > 1023) ? 1023 : m_hit + k;
           end else if (m_pressd && !last) begin
             m_combo = 0;
             m_miss = (m_miss + 1 > 1023) ? 1023 : m_miss + 1;
           end
           if (last) m_state = 2;
           else m_timer++;
         end
      2: if (kc == 8'h01) m_state = 0;
      default: m_state = 0;
    endcase
    m_pressd     = arrow && !m_arrow_prev;
    m_arrow_prev = arrow;
    m_prev       = sin;
  endtask

  // One frame: advance the model on the current inputs, then clock the DUTs.
  task automatic tick();
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int e_tot, input int e_cmb,
                          input int e_mx, input int e_hit, input int e_mis, input int e_st);
    chk({tag, ".total"}, int'(tot), e_tot);
    chk({tag, ".combo"}, int'(cmb), e_cmb);
    chk({tag, ".max"},   int'(mx),  e_mx);
    chk({tag, ".hits"},  int'(hit), e_hit);
    chk({tag, ".miss"},  int'(mis), e_mis);
    chk({tag, ".state"}, int'(st),  e_st);
    chk({tag, ".over"},  int'(go),  (e_st == 2) ? 1 : 0);
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  kc;
    logic [7:0]  kc2;
    logic [31:0] sin;
    int tot, cmb, mx, hit, mis, st;
  } vec_t;

  vec_t tv[15];

  initial begin
    rst = 1'b1; kc = 8'h00; kc2 = 8'h00; sin = '0;
    step_model();

    // Expected values are the outputs right after the frame's clock edge.
    tv[0]  = '{1'b1, 8'h00, 8'h00, 32'h0, 0,  0, 0, 0, 0, 0}; // reset
    tv[1]  = '{1'b0, 8'h2C, 8'h00, 32'h0, 0,  0, 0, 0, 0, 1}; // start
    tv[2]  = '{1'b0, 8'h00, 8'h00, 32'h1, 10, 1, 1, 1, 0, 1}; // single hit
    tv[3]  = '{1'b0, 8'h50, 8'h00, 32'h1, 10, 1, 1, 1, 0, 1}; // press edge
    tv[4]  = '{1'b0, 8'h50, 8'h00, 32'h1, 10, 0, 1, 1, 1, 1}; // miss
    tv[5]  = '{1'b0, 8'h00, 8'h00, 32'hE, 40, 3, 3, 4, 1, 1}; // 3 at once
    tv[6]  = '{1'b0, 8'h52, 8'h00, 32'hE, 40, 3, 3, 4, 1, 1}; // press edge
    tv[7]  = '{1'b0, 8'h52, 8'h00, 32'hF, 50, 4, 4, 5, 1, 1}; // press+hit
    tv[8]  = '{1'b0, 8'h00, 8'h00, 32'hF, 50, 4, 4, 5, 1, 1};
    tv[9]  = '{1'b0, 8'h00, 8'h4F, 32'hF, 50, 4, 4, 5, 1, 1}; // 2nd key edge
    tv[10] = '{1'b0, 8'h00, 8'h00, 32'hF, 50, 0, 4, 5, 2, 1}; // miss
    tv[11] = '{1'b1, 8'h00, 8'h00, 32'hF, 0,  0, 0, 0, 0, 0}; // mid-PLAY reset
    tv[12] = '{1'b0, 8'h00, 8'h00, 32'hF, 0,  0, 0, 0, 0, 0};
    tv[13] = '{1'b0, 8'h2C, 8'h00, 32'hF, 0,  0, 0, 0, 0, 1};
    tv[14] = '{1'b0, 8'h00, 8'h00, 32'hF, 0,  0, 0, 0, 0, 1}; // stale levels

    for (int i = 0; i < 15; i++) begin
      rst = tv[i].rst; kc = tv[i].kc; kc2 = tv[i].kc2; sin = tv[i].sin;
      tick();
      chk_main($sformatf("vec%0d", i), tv[i].tot, tv[i].cmb, tv[i].mx,
               tv[i].hit, tv[i].mis, tv[i].st);
    end

    // Twelve successive single hits: bonus starts at the 11th.
    rst = 1'b1; kc = 8'h00; kc2 = 8'h00; sin = '0; tick();
    rst = 1'b0; kc = 8'h2C; tick();
    kc = 8'h00;
    for (int i = 0; i < 12; i++) begin
      sin = 32'h1 << i;
      tick();
      if (i == 9)  chk("streak.after10", int'(tot), 100);
      if (i == 10) chk("streak.after11", int'(tot), 120);
    end
    chk_main("streak12", 140, 12, 12, 12, 0, 1);

    // Short game: end of PLAY, final-frame press ignored, frozen DONE.
    rst = 1'b1; kc = 8'h00; sin = '0; tick();
    rst = 1'b0; kc = 8'h2C; tick();
    for (int i = 1; i <= 8; i++) begin
      kc = (i == 7) ? 8'h50 : 8'h00;
      tick();
      if (i == 7) chk("g8.state_f7", int'(st8), 1);
    end
    chk("g8.state_done", int'(st8), 2);
    chk("g8.over", int'(go8), 1);
    chk("g8.lastpress", int'(mis8), 0);
    sin = 32'h1; tick();
    chk("g8.done_hit", int'(hit8), 0);
    chk("g8.done_total", int'(tot8), 0);
    kc = 8'h51; tick(); kc = 8'h00; tick(); tick();
    chk("g8.done_miss", int'(mis8), 0);
    chk("g8.hold", int'(st8), 2);
    kc = 8'h01; tick();
    chk("g8.idle", int'(st8), 0);
    chk("g8.over_clr", int'(go8), 0);

    // Burst game: every dropper rises on alternate frames, driving all
    // saturation limits; checked against the model and fixed end values.
    kc = 8'h00; sin = '0; rst = 1'b1; tick();
    rst = 1'b0; kc = 8'h2C; tick();
    kc = 8'h00;
    for (int i = 0; i < GL; i++) begin
      sin = (i % 2 == 0) ? '1 : '0;
      tick();
      chk_main($sformatf("burst%0d", i), m_total, m_combo, m_max, m_hit, m_miss, m_state);
    end
    chk_main("burst.end", 9999, 255, 255, 1023, 0, 2);

    // Random play against the model.
    rst = 1'b1; sin = '0; tick();
    for (int c = 0; c < 3000; c++) begin
      int r;
      rst = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 15);
      if (r <= 5)       kc = 8'h00;
      else if (r == 6)  kc = 8'h2C;
      else if (r == 7)  kc = 8'h01;
      else if (r <= 11) kc = 8'h4F + 8'(r - 8);
      else              kc = 8'($urandom);
      kc2 = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h4F + 8'($urandom_range(0, 3));
      sin = sin ^ ($urandom & $urandom & $urandom);
      tick();
      chk_main($sformatf("rnd%0d", c), m_total, m_combo, m_max, m_hit, m_miss, m_state);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
